// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Divisors are passed through 32-bit helpers and truncated back to DIV_W by the caller.
package clock_divider_pkg;

    localparam int DIV_MIN = 2;

    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < 32'(DIV_MIN)) ? 32'(DIV_MIN) : v;
    endfunction

    // High-phase length for a period of v cycles.
    function automatic logic [31:0] half_div(input logic [31:0] v);
        return v >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_duty_stage.sv
// Half-cycle extender: stretches the high phase of an odd divisor by half a clk period.
// Only instantiated when CLOCK_DIVIDER_PROG_DUTY50_EN is defined.
module clkdiv_duty_stage #(
    parameter bit ODD_RESET = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic update,
    input  logic odd_next,
    input  logic pos_clk,
    output logic out_clk
);

    logic odd_q;
    logic neg_q;

    // odd_q follows the divisor that governs the current period.
    always_ff @(posedge clk) begin
        if (reset) begin
            odd_q <= ODD_RESET;
        end else if (update) begin
            odd_q <= odd_next;
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_clk & odd_q;
        end
    end

    assign out_clk = pos_clk | neg_q;

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor switching.
// Define CLOCK_DIVIDER_PROG_DUTY50_EN to add the negedge stage giving 50% duty for odd divisors.
module clock_divider_prog
    import clock_divider_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_busy,
    output logic [DIV_W-1:0] active_div,
    output logic             out_clk,
    output logic             out_tick
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] pending;
    logic [DIV_W-1:0] div_req;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] n_new;
    logic             boundary;
    logic             update;
    logic             pos_clk;

    always_comb begin
        div_req  = DIV_W'(clamp_div(32'(div_val)));
        half     = DIV_W'(half_div(32'(active_div)));
        boundary = (cnt >= active_div - DIV_W'(1));
        cnt_next = boundary ? '0 : cnt + DIV_W'(1);
        // A divisor switch happens only at a period boundary or while parked.
        update   = 1'b0;
        n_new    = active_div;
        if (!en || boundary) begin
            if (div_load) begin
                update = 1'b1;
                n_new  = div_req;
            end else if (div_busy) begin
                update = 1'b1;
                n_new  = pending;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            active_div <= DIV_RST;
            pending    <= DIV_RST;
            div_busy   <= 1'b0;
            pos_clk    <= 1'b0;
            out_tick   <= 1'b0;
        end else begin
            if (div_load) begin
                pending <= div_req;
            end
            div_busy <= update ? 1'b0 : (div_load | div_busy);
            if (update) begin
                active_div <= n_new;
            end
            if (en) begin
                cnt      <= cnt_next;
                pos_clk  <= (cnt_next < half);
                out_tick <= boundary;
            end else begin
                // Parking at N-1 makes the first enabled edge a boundary.
                cnt      <= n_new - DIV_W'(1);
                pos_clk  <= 1'b0;
                out_tick <= 1'b0;
            end
        end
    end

`ifdef CLOCK_DIVIDER_PROG_DUTY50_EN
    clkdiv_duty_stage #(
        .ODD_RESET (DIV_RST[0])
    ) u_duty (
        .clk      (clk),
        .reset    (reset),
        .update   (update),
        .odd_next (n_new[0]),
        .pos_clk  (pos_clk),
        .out_clk  (out_clk)
    );
`else
    assign out_clk = pos_clk;
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog (default build, no duty-cycle stage).
// Each step drives inputs, waits one rising edge, then checks against hand-computed values.
module tb_clock_divider_prog;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] div_val;
    logic       div_load;
    logic       div_busy;
    logic [7:0] active_div;
    logic       out_clk;
    logic       out_tick;

    int vec_cnt;
    int miscompares;

    clock_divider_prog #(
        .DIV_W       (8),
        .DIV_DEFAULT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .div_val    (div_val),
        .div_load   (div_load),
        .div_busy   (div_busy),
        .active_div (active_div),
        .out_clk    (out_clk),
        .out_tick   (out_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, advance one edge, sample 1 ns later.
    task automatic step(input logic e, input logic ld, input logic [7:0] v);
        en       = e;
        div_load = ld;
        div_val  = v;
        @(posedge clk);
        #1;
        div_load = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int c, input int t, input int b, input int d);
        check({tag, ".out_clk"}, int'(out_clk), c);
        check({tag, ".out_tick"}, int'(out_tick), t);
        check({tag, ".div_busy"}, int'(div_busy), b);
        check({tag, ".active_div"}, int'(active_div), d);
    endtask

    int exp_c4 [9] = '{1, 1, 0, 0, 1, 1, 0, 0, 1};
    int exp_t4 [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int exp_c5 [6] = '{1, 1, 0, 0, 0, 1};
    int exp_t5 [6] = '{1, 0, 0, 0, 0, 1};
    int exp_c8 [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    int exp_t8 [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        vec_cnt     = 0;
        miscompares = 0;
        reset       = 1'b1;
        en          = 1'b0;
        div_load    = 1'b0;
        div_val     = '0;
        step(0, 0, 0);
        step(0, 0, 0);
        expect_out("reset", 0, 0, 0, 4);

        reset = 1'b0;
        step(0, 0, 0);
        expect_out("park", 0, 0, 0, 4);

        // Default N=4: 1,1,0,0 with a tick every 4th edge.
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 0);
            expect_out($sformatf("n4[%0d]", i), exp_c4[i], exp_t4[i], 0, 4);
        end

        // Load 5 mid-period; switch waits for the boundary.
        step(1, 0, 0);
        expect_out("n4_cnt1", 1, 0, 0, 4);
        step(1, 1, 8'd5);
        expect_out("load5", 0, 0, 1, 4);
        step(1, 0, 0);
        expect_out("load5_wait", 0, 0, 1, 4);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0);
            expect_out($sformatf("n5[%0d]", i), exp_c5[i], exp_t5[i], 0, 5);
        end

        // Loads of 0 and 1 both clamp to 2.
        step(1, 1, 8'd0);
        expect_out("load0", 1, 0, 1, 5);
        step(1, 1, 8'd1);
        expect_out("load1", 0, 0, 1, 5);
        step(1, 0, 0);
        expect_out("clamp_wait0", 0, 0, 1, 5);
        step(1, 0, 0);
        expect_out("clamp_wait1", 0, 0, 1, 5);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0);
            expect_out($sformatf("n2[%0d]", i), (i % 2 == 0) ? 1 : 0, (i % 2 == 0) ? 1 : 0, 0, 2);
        end

        // Load 7 then 3 on the boundary edge: 3 takes effect there, busy drops.
        step(1, 1, 8'd7);
        expect_out("load7", 0, 0, 1, 2);
        step(1, 1, 8'd3);
        expect_out("load3_bnd", 1, 1, 0, 3);
        step(1, 0, 0);
        expect_out("n3[1]", 0, 0, 0, 3);
        step(1, 0, 0);
        expect_out("n3[2]", 0, 0, 0, 3);
        step(1, 0, 0);
        expect_out("n3[3]", 1, 1, 0, 3);

        // Back-to-back 7 then 6 before the boundary: only 6 is applied.
        step(1, 1, 8'd7);
        expect_out("b2b7", 0, 0, 1, 3);
        step(1, 1, 8'd6);
        expect_out("b2b6", 0, 0, 1, 3);
        step(1, 0, 0);
        expect_out("n6[0]", 1, 1, 0, 6);
        step(1, 0, 0);
        expect_out("n6[1]", 1, 0, 0, 6);

        // Load 8 in the high phase, then drop en: applied at once.
        step(1, 1, 8'd8);
        expect_out("load8", 1, 0, 1, 6);
        step(0, 0, 0);
        expect_out("en_off0", 0, 0, 0, 8);
        step(0, 0, 0);
        expect_out("en_off1", 0, 0, 0, 8);
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 0);
            expect_out($sformatf("n8[%0d]", i), exp_c8[i], exp_t8[i], 0, 8);
        end

        // Reloading the active value still holds busy until the boundary.
        step(1, 1, 8'd8);
        expect_out("same8", 1, 0, 1, 8);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0);
            check($sformatf("same8_busy[%0d]", i), int'(div_busy), 1);
        end
        step(1, 0, 0);
        expect_out("same8_bnd", 1, 1, 0, 8);

        // Reset mid-period discards a pending load.
        step(1, 1, 8'd5);
        expect_out("pre_rst", 1, 0, 1, 8);
        reset = 1'b1;
        step(1, 0, 0);
        expect_out("mid_rst", 0, 0, 0, 4);
        reset = 1'b0;

        // Max divisor: load while parked applies immediately.
        step(0, 1, 8'd255);
        expect_out("load255", 0, 0, 0, 255);
        for (int i = 0; i < 256; i++) begin
            step(1, 0, 0);
            check($sformatf("n255_clk[%0d]", i), int'(out_clk), ((i % 255) < 127) ? 1 : 0);
            check($sformatf("n255_tick[%0d]", i), int'(out_tick), ((i % 255) == 0) ? 1 : 0);
        end
        check("n255_div", int'(active_div), 255);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
